// File: rtl/regfile_wb_arbiter_if.sv
// regfile_wb_arbiter_if: writeback requester bundle and register-file write port of regfile_wb_arbiter
interface regfile_wb_arbiter_if #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
);
    localparam int G_W = $clog2(N_REQ);
    logic [N_REQ-1:0]        req_valid;
    logic [ADDR_W*N_REQ-1:0] req_rd;
    logic [DATA_W*N_REQ-1:0] req_data;
    logic [N_REQ-1:0]        req_ready;
    logic                    wen;
    logic [ADDR_W-1:0]       rd;
    logic [DATA_W-1:0]       Rd;
    logic [G_W-1:0]          grant_id;
    logic [CNT_W-1:0]        drop_cnt;
    modport master (
        output req_valid, req_rd, req_data,
        input  req_ready, wen, rd, Rd, grant_id, drop_cnt
    );
    modport slave (
        input  req_valid, req_rd, req_data,
        output req_ready, wen, rd, Rd, grant_id, drop_cnt
    );
endinterface

// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: round-robin writeback port arbiter with r0 drop counter; WBARB_FIXED_PRIO_EN selects fixed priority
module regfile_wb_arbiter #(
    parameter int N_REQ  = 3,
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input logic clk,
    input logic rst,
    regfile_wb_arbiter_if.slave bus
);
    localparam int G_W = $clog2(N_REQ);
    logic [G_W-1:0]    w_ptr;
    logic [G_W-1:0]    w_gnt;
    logic              w_any;
    logic [ADDR_W-1:0] w_rd;
    logic [DATA_W-1:0] w_data;
    logic              r_wen;
    logic [ADDR_W-1:0] r_rd;
    logic [DATA_W-1:0] r_data;
    logic [G_W-1:0]    r_gid;
    logic [CNT_W-1:0]  r_cnt;
    always_comb begin
        w_gnt = '0;
        w_any = 1'b0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            if (bus.req_valid[(int'(w_ptr) + k) % N_REQ]) begin
                w_gnt = G_W'((int'(w_ptr) + k) % N_REQ);
                w_any = 1'b1;
            end
        end
    end
    assign w_rd          = bus.req_rd[w_gnt*ADDR_W +: ADDR_W];
    assign w_data        = bus.req_data[w_gnt*DATA_W +: DATA_W];
    assign bus.req_ready = (w_any && !rst) ? N_REQ'(1) << w_gnt : '0;
`ifdef WBARB_FIXED_PRIO_EN
    assign w_ptr = '0;
`else
    logic [G_W-1:0] r_ptr;
    always_ff @(posedge clk) begin
        if (rst)
            r_ptr <= '0;
        else if (w_any)
            r_ptr <= (w_gnt == G_W'(N_REQ - 1)) ? '0 : w_gnt + 1'b1;
    end
    assign w_ptr = r_ptr;
`endif
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wen  <= 1'b0;
            r_rd   <= '0;
            r_data <= '0;
            r_gid  <= '0;
            r_cnt  <= '0;
        end else begin
            r_wen <= w_any && (w_rd != '0);
            if (w_any) begin
                r_rd   <= w_rd;
                r_data <= w_data;
                r_gid  <= w_gnt;
                if (w_rd == '0 && !(&r_cnt))
                    r_cnt <= r_cnt + 1'b1;
            end
        end
    end
    assign bus.wen      = r_wen;
    assign bus.rd       = r_rd;
    assign bus.Rd       = r_data;
    assign bus.grant_id = r_gid;
    assign bus.drop_cnt = r_cnt;
endmodule
